// File: rtl/sync_marker_pkg.sv
// Shared constants and types for the sync-marker serial transmitter.
package sync_marker_pkg;

  localparam int SYNC_W     = 5;
  localparam int SYNC_IDX_W = $clog2(SYNC_W);
  // Bit 0 goes out first, so the line sees 1,1,1,0,0.
  localparam logic [SYNC_W-1:0] SYNC_MARKER = 5'b00111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    DATA   = 2'd2,
    PARITY = 2'd3
  } tx_state_t;

  function automatic logic sync_bit(input logic [SYNC_IDX_W-1:0] idx);
    return SYNC_MARKER[idx];
  endfunction

endpackage

// File: rtl/sync_marker_fifo.sv
// Small synchronous first-word-fall-through FIFO; flags are registered from
// the next occupancy so they always agree with count.
module sync_marker_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     half,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count_nxt;
  logic              push_ok;
  logic              pop_ok;

  // A push into a full FIFO still lands when a pop frees the slot that cycle.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop_ok)
      count_nxt = count + 1'b1;
    else if (!push_ok && pop_ok)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      half   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      half  <= (count_nxt >= CW'(DEPTH / 2));
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/sync_marker_tx.sv
// Framed serial transmitter: 5-bit sync marker then payload LSB first.
// Optional SYNC_MARKER_TX_PARITY_EN appends an even-parity bit to each frame.
module sync_marker_tx
  import sync_marker_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int OS_RATE    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_16_x_baud,
  input  logic [DATA_W-1:0] data_in,
  input  logic              write_buffer,
  output logic              serial_out,
  output logic              buffer_full,
  output logic              buffer_half_full,
  output logic              buffer_empty,
  output logic              tx_busy,
  output logic              overflow
);

  localparam int CW   = $clog2(FIFO_DEPTH) + 1;
  localparam int OS_W = $clog2(OS_RATE);
  localparam int BC_W = $clog2((DATA_W > SYNC_W) ? DATA_W : SYNC_W);

  tx_state_t         state;
  logic [OS_W-1:0]   os_cnt;
  logic [BC_W-1:0]   bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] fifo_dout;
  logic [CW-1:0]     fifo_count;
  logic              has_data;
  logic              bit_done;
  logic              frame_end;
  logic              pop;
`ifdef SYNC_MARKER_TX_PARITY_EN
  logic              parity;
`endif

  sync_marker_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (write_buffer),
    .pop   (pop),
    .din   (data_in),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (buffer_full),
    .half  (buffer_half_full),
    .empty (buffer_empty)
  );

  assign has_data = (fifo_count != '0);
  assign bit_done = (state != IDLE) && en_16_x_baud && (os_cnt == OS_W'(OS_RATE - 1));
`ifdef SYNC_MARKER_TX_PARITY_EN
  assign frame_end = bit_done && (state == PARITY);
`else
  assign frame_end = bit_done && (state == DATA) && (bit_cnt == BC_W'(DATA_W - 1));
`endif
  // Popping at frame end keeps consecutive frames back to back with no gap.
  assign pop = has_data && ((state == IDLE) || frame_end);

  always_ff @(posedge clk) begin
    if (pop)
      shreg <= fifo_dout;
    else if (bit_done && (state == DATA))
      shreg <= shreg >> 1;
  end

`ifdef SYNC_MARKER_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (pop)
      parity <= ^fifo_dout;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      os_cnt     <= '0;
      bit_cnt    <= '0;
      serial_out <= 1'b0;
      tx_busy    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      overflow <= write_buffer && buffer_full && !pop;
      if (pop) begin
        state      <= SYNC;
        bit_cnt    <= '0;
        os_cnt     <= '0;
        tx_busy    <= 1'b1;
        serial_out <= sync_bit('0);
      end else if (frame_end) begin
        state      <= IDLE;
        bit_cnt    <= '0;
        os_cnt     <= '0;
        tx_busy    <= 1'b0;
        serial_out <= 1'b0;
      end else if ((state != IDLE) && en_16_x_baud) begin
        if (!bit_done) begin
          os_cnt <= os_cnt + 1'b1;
        end else begin
          os_cnt <= '0;
          case (state)
            SYNC: begin
              if (bit_cnt == BC_W'(SYNC_W - 1)) begin
                state      <= DATA;
                bit_cnt    <= '0;
                serial_out <= shreg[0];
              end else begin
                bit_cnt    <= bit_cnt + 1'b1;
                serial_out <= sync_bit(SYNC_IDX_W'(bit_cnt + 1'b1));
              end
            end
            DATA: begin
              if (bit_cnt == BC_W'(DATA_W - 1)) begin
`ifdef SYNC_MARKER_TX_PARITY_EN
                state      <= PARITY;
                serial_out <= parity;
`endif
              end else begin
                bit_cnt    <= bit_cnt + 1'b1;
                serial_out <= shreg[1];
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_sync_marker_tx.sv
// Bench for sync_marker_tx: directed table, hand sequences and a frame-level reference model.
module tb_sync_marker_tx;

  localparam int DEPTH = 4;
  localparam int OS    = 16;
`ifdef SYNC_MARKER_TX_PARITY_EN
  localparam int NBITS = 14;
`else
  localparam int NBITS = 13;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_16_x_baud = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       write_buffer = 1'b0;
  logic       serial_out, buffer_full, buffer_half_full, buffer_empty, tx_busy, overflow;

  sync_marker_tx #(.DATA_W(8), .FIFO_DEPTH(DEPTH), .OS_RATE(OS)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .en_16_x_baud     (en_16_x_baud),
    .data_in          (data_in),
    .write_buffer     (write_buffer),
    .serial_out       (serial_out),
    .buffer_full      (buffer_full),
    .buffer_half_full (buffer_half_full),
    .buffer_empty     (buffer_empty),
    .tx_busy          (tx_busy),
    .overflow         (overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: queue of pending bytes plus the remaining bits of the frame on the line.
  logic [7:0] mq[$];
  bit         frame[$];
  int         m_enc;
  bit         m_busy;
  bit         m_ovf;

  function automatic logic [5:0] outs();
    return {serial_out, buffer_full, buffer_half_full, buffer_empty, tx_busy, overflow};
  endfunction

  function automatic logic [5:0] model_outs();
    logic line;
    line = m_busy ? frame[0] : 1'b0;
    return {line, mq.size() == DEPTH, mq.size() >= DEPTH / 2, mq.size() == 0, m_busy, m_ovf};
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b expected %b (line,full,half,empty,busy,ovf)", name, $time, act, exp);
    end
  endtask

  task automatic build_frame(input logic [7:0] b);
    frame.delete();
    frame.push_back(1'b1); frame.push_back(1'b1); frame.push_back(1'b1);
    frame.push_back(1'b0); frame.push_back(1'b0);
    for (int i = 0; i < 8; i++) frame.push_back(b[i]);
`ifdef SYNC_MARKER_TX_PARITY_EN
    frame.push_back(^b);
`endif
  endtask

  task automatic model_reset();
    mq.delete(); frame.delete();
    m_enc = 0; m_busy = 0; m_ovf = 0;
  endtask

  task automatic model_step(input bit w, input logic [7:0] d, input bit e);
    bit ended, start, accept, dummy;
    ended  = m_busy && e && (m_enc == OS - 1) && (frame.size() == 1);
    start  = (mq.size() != 0) && (!m_busy || ended);
    accept = w && ((mq.size() < DEPTH) || start);
    m_ovf  = w && !accept;
    if (start) begin
      build_frame(mq.pop_front());
      m_enc = 0; m_busy = 1;
    end else if (ended) begin
      frame.delete(); m_busy = 0; m_enc = 0;
    end else if (m_busy && e) begin
      if (m_enc == OS - 1) begin
        m_enc = 0; dummy = frame.pop_front();
      end else begin
        m_enc++;
      end
    end
    if (accept) mq.push_back(d);
  endtask

  task automatic cycle(input bit w, input logic [7:0] d, input bit e);
    write_buffer = w; data_in = d; en_16_x_baud = e;
    @(posedge clk);
    model_step(w, d, e);
    @(negedge clk);
    check("model", outs(), model_outs());
    write_buffer = 1'b0; en_16_x_baud = 1'b0;
  endtask

  task automatic apply_reset();
    write_buffer = 1'b0; en_16_x_baud = 1'b0; data_in = 8'h00;
    rst_n = 1'b0;
    #1;
    check("reset_async", outs(), 6'b000100);
    model_reset();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic parity_case(input logic [7:0] b, input logic exp_bit);
    cycle(1'b1, b, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    repeat (13 * OS + OS / 2) cycle(1'b0, 8'h00, 1'b1);
    check("parity_bit", {5'b0, serial_out}, {5'b0, exp_bit});
    repeat (OS / 2 + 4) cycle(1'b0, 8'h00, 1'b1);
    check("parity_end", outs(), 6'b000100);
  endtask

  typedef struct {
    bit         w;
    logic [7:0] d;
    bit         e;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[8];
  bit   a5_bits[NBITS];
  int   rate[4];

  initial begin
    // Stalled enable: six writes, first pops at once, four queue, sixth overflows.
    tbl[0] = '{1'b0, 8'h00, 1'b0, 6'b000100};
    tbl[1] = '{1'b1, 8'h01, 1'b0, 6'b000000};
    tbl[2] = '{1'b1, 8'hFF, 1'b0, 6'b100010};
    tbl[3] = '{1'b1, 8'h80, 1'b0, 6'b101010};
    tbl[4] = '{1'b1, 8'h11, 1'b0, 6'b101010};
    tbl[5] = '{1'b1, 8'h22, 1'b0, 6'b111010};
    tbl[6] = '{1'b1, 8'h33, 1'b0, 6'b111011};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 6'b111010};
    a5_bits = '{default: 1'b0};
    a5_bits[0] = 1; a5_bits[1] = 1; a5_bits[2] = 1; a5_bits[3] = 0; a5_bits[4] = 0;
    a5_bits[5] = 1; a5_bits[6] = 0; a5_bits[7] = 1; a5_bits[8] = 0;
    a5_bits[9] = 0; a5_bits[10] = 1; a5_bits[11] = 0; a5_bits[12] = 1;
    rate[0] = 3; rate[1] = 25; rate[2] = 150; rate[3] = 600;

    rst_n = 1'b1;
    #2;
    apply_reset();
    repeat (50) cycle(1'b0, 8'h00, 1'b0);
    check("idle", outs(), 6'b000100);

    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].w, tbl[i].d, tbl[i].e);
      check($sformatf("table[%0d]", i), outs(), tbl[i].exp);
    end

    // Finish the first frame with one enable to spare, then write on the popping edge.
    repeat (NBITS * OS - 1) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'h44, 1'b1);
    check("write_on_pop", outs(), 6'b111010);
    repeat (5 * NBITS * OS + 20) cycle(1'b0, 8'h00, 1'b1);
    check("drained", outs(), 6'b000100);

    // 0xA5 with an enable every 4th clock.
    apply_reset();
    cycle(1'b1, 8'hA5, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    for (int k = 0; k < NBITS; k++) begin
      for (int g = 0; g < OS; g++) begin
        repeat (3) cycle(1'b0, 8'h00, 1'b0);
        if (g == OS / 2)
          check($sformatf("a5_bit%0d", k), {5'b0, serial_out}, {5'b0, a5_bits[k]});
        if (k == NBITS - 1 && g == OS - 1)
          check("a5_busy_last", {5'b0, tx_busy}, 6'b000001);
        cycle(1'b0, 8'h00, 1'b1);
      end
    end
    check("a5_end", outs(), 6'b000100);

    // Reset during data bit 3 of 0xC3 with another byte still queued.
    apply_reset();
    cycle(1'b1, 8'hC3, 1'b0);
    cycle(1'b1, 8'h5A, 1'b0);
    repeat (8 * OS + OS / 2) cycle(1'b0, 8'h00, 1'b1);
    check("c3_before_rst", {4'b0, tx_busy, buffer_empty}, 6'b000010);
    apply_reset();
    repeat (300) cycle(1'b0, 8'h00, 1'b1);
    check("c3_no_frame", outs(), 6'b000100);

`ifdef SYNC_MARKER_TX_PARITY_EN
    apply_reset();
    parity_case(8'h07, 1'b1);
    parity_case(8'h03, 1'b0);
`endif

    // Randomized traffic at several write densities.
    apply_reset();
    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 1500; i++) begin
        bit         w, e;
        logic [7:0] d;
        w = ($urandom_range(0, rate[blk]) == 0);
        e = (blk % 2 == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
        d = 8'($urandom);
        cycle(w, d, e);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
